// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: N-channel switch-gated LED driver.
// Each switch is synchronized and debounced; the debounced state gates an LED
// pattern (blink, chase, PWM dimming or steady) advanced once per tick period.
// Ports:
//   clk_125     system clock
//   reset_n     asynchronous active-low reset
//   sw          raw board switches (asynchronous)
//   mode        display mode: 0=BLINK, 1=CHASE, 2=PWM, 3=STEADY
//   brightness  PWM duty value used in PWM mode
//   led         registered LED drive
//   sw_db       debounced switch state
//   sw_rise     one-cycle pulse on a debounced 0->1 transition
//   tick        one-cycle pulse at the end of each tick period
module led_pattern_ctrl #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned TICK_PERIOD     = 6250000,
    parameter int unsigned DEBOUNCE_CYCLES = 625000,
    parameter int unsigned PWM_BITS        = 8
) (
    input  logic                clk_125,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   sw,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_CH-1:0]   led,
    output logic [NUM_CH-1:0]   sw_db,
    output logic [NUM_CH-1:0]   sw_rise,
    output logic                tick
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TK_W = $clog2(TICK_PERIOD);

    localparam logic [1:0] MODE_BLINK = 2'd0;
    localparam logic [1:0] MODE_CHASE = 2'd1;
    localparam logic [1:0] MODE_PWM   = 2'd2;

    // Pattern a mode starts from after reset or on entry to that mode.
    function automatic logic [NUM_CH-1:0] init_pattern(input logic [1:0] m);
        logic [NUM_CH-1:0] p;
        p = '1;
        case (m)
            MODE_BLINK: for (int i = 0; i < NUM_CH; i++) p[i] = 1'(i % 2);
            MODE_CHASE: p = NUM_CH'(1);
            default:    p = '1;
        endcase
        return p;
    endfunction

    // Two-flop synchronizer for the raw switches.
    logic [NUM_CH-1:0] sw_meta;
    logic [NUM_CH-1:0] sw_s;

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    // Per-channel debounce: accept a new level after DEBOUNCE_CYCLES
    // consecutive mismatching samples; any matching sample restarts the count.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_db
        logic [DB_W-1:0] db_cnt;
        logic            db_q;
        logic            rise_q;

        always_ff @(posedge clk_125 or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                if (sw_s[g] == db_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt <= '0;
                    db_q   <= sw_s[g];
                    rise_q <= sw_s[g];
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign sw_db[g]   = db_q;
        assign sw_rise[g] = rise_q;
    end

    // Tick timer, pattern sequencer, PWM counter and LED output register.
    logic [1:0]          mode_q;
    logic [TK_W-1:0]     tick_cnt;
    logic [NUM_CH-1:0]   pattern;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                mode_chg_c;
    logic                tick_wrap_c;
    logic                pwm_on_c;

    assign mode_chg_c  = (mode != mode_q);
    assign tick_wrap_c = (tick_cnt == TK_W'(TICK_PERIOD - 1));
    assign pwm_on_c    = (pwm_cnt < brightness);

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= MODE_BLINK;
            tick_cnt <= '0;
            tick     <= 1'b0;
            pattern  <= init_pattern(MODE_BLINK);
            pwm_cnt  <= '0;
            led      <= '0;
        end else begin
            mode_q  <= mode;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            // A mode change restarts the period and overrides a coincident tick.
            tick    <= tick_wrap_c & ~mode_chg_c;
            if (mode_chg_c) begin
                tick_cnt <= '0;
                pattern  <= init_pattern(mode);
            end else begin
                tick_cnt <= tick_wrap_c ? '0 : tick_cnt + TK_W'(1);
                if (tick_wrap_c) begin
                    case (mode_q)
                        MODE_BLINK: pattern <= ~pattern;
                        MODE_CHASE: pattern <= {pattern[NUM_CH-2:0], pattern[NUM_CH-1]};
                        default:    pattern <= '1;
                    endcase
                end
            end
            led <= sw_db & pattern & ((mode_q == MODE_PWM) ? {NUM_CH{pwm_on_c}} : {NUM_CH{1'b1}});
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against an arithmetic reference model.
module tb_led_pattern_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned TP = 10;
    localparam int unsigned DC = 4;
    localparam int unsigned PB = 4;

    logic          clk_125 = 1'b0;
    logic          reset_n = 1'b1;
    logic [N-1:0]  sw = '0;
    logic [1:0]    mode = '0;
    logic [PB-1:0] brightness = '0;
    logic [N-1:0]  led;
    logic [N-1:0]  sw_db;
    logic [N-1:0]  sw_rise;
    logic          tick;

    int checks   = 0;
    int failures = 0;

    led_pattern_ctrl #(
        .NUM_CH         (N),
        .TICK_PERIOD    (TP),
        .DEBOUNCE_CYCLES(DC),
        .PWM_BITS       (PB)
    ) dut (
        .clk_125   (clk_125),
        .reset_n   (reset_n),
        .sw        (sw),
        .mode      (mode),
        .brightness(brightness),
        .led       (led),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .tick      (tick)
    );

    always #4 clk_125 = ~clk_125;

    // Reference model state. ep counts clock edges since reset release;
    // anchor is the edge of the last reset release or mode change.
    int unsigned  ep;
    int unsigned  anchor;
    logic [1:0]   mq_m;
    logic [N-1:0] in_q[$];
    logic [N-1:0] win_q[$];
    logic [N-1:0] db_m;
    logic [N-1:0] rise_m;
    logic [N-1:0] led_m;
    logic         tick_m;

    // Pattern j edges after entering mode m: one step per completed period.
    function automatic logic [N-1:0] pat_of(input int unsigned j, input logic [1:0] m);
        int unsigned  k;
        logic [N-1:0] p;
        k = j / TP;
        p = '1;
        case (m)
            2'd0: begin
                for (int i = 0; i < N; i++) p[i] = (i % 2 == 1);
                if (k % 2 == 1) p = ~p;
            end
            2'd1: p = N'(1) << (k % N);
            default: p = '1;
        endcase
        return p;
    endfunction

    task automatic model_reset();
        ep     = 0;
        anchor = 0;
        mq_m   = 2'd0;
        db_m   = '0;
        rise_m = '0;
        led_m  = '0;
        tick_m = 1'b0;
        in_q.delete();
        in_q.push_back('0);
        in_q.push_back('0);
        win_q.delete();
        for (int i = 0; i < DC; i++) win_q.push_back('0);
    endtask

    // Advance the model across one clock edge using the inputs seen there.
    task automatic model_edge();
        logic [N-1:0] mask;
        logic [N-1:0] w;
        logic         all_diff;
        mask = '1;
        if (mq_m == 2'd2 && !((ep % (1 << PB)) < 32'(brightness))) mask = '0;
        led_m = db_m & pat_of(ep - anchor, mq_m) & mask;

        // Debounced level flips once the last DC synchronized samples all disagree.
        win_q.push_front(in_q[1]);
        void'(win_q.pop_back());
        rise_m = '0;
        for (int ch = 0; ch < N; ch++) begin
            all_diff = 1'b1;
            for (int d = 0; d < DC; d++) begin
                w = win_q[d];
                if (w[ch] == db_m[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                db_m[ch]   = ~db_m[ch];
                rise_m[ch] = db_m[ch];
            end
        end
        in_q.push_front(sw);
        void'(in_q.pop_back());

        ep = ep + 1;
        if (mode != mq_m) begin
            anchor = ep;
            mq_m   = mode;
            tick_m = 1'b0;
        end else begin
            tick_m = ((ep - anchor) % TP == 0);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_led"},     32'(led),     32'(0));
        chk({tag, "_sw_db"},   32'(sw_db),   32'(0));
        chk({tag, "_sw_rise"}, 32'(sw_rise), 32'(0));
        chk({tag, "_tick"},    32'(tick),    32'(0));
    endtask

    // One clock: update model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk_125);
        model_edge();
        @(negedge clk_125);
        chk("led",     32'(led),     32'(led_m));
        chk("sw_db",   32'(sw_db),   32'(db_m));
        chk("sw_rise", 32'(sw_rise), 32'(rise_m));
        chk("tick",    32'(tick),    32'(tick_m));
    endtask

    initial begin
        int first;
        int rises;
        int rise_at;
        int seen_db;
        int seen_rise;
        int t1;
        int t2;
        int tcnt;
        int on_cnt;
        int hi_cnt;
        int idx;

        model_reset();
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk_125);
        reset_n = 1'b1;

        // Debounce accept on channel 0.
        sw = 4'b0001;
        first = 0; rises = 0; rise_at = 0;
        for (int n = 1; n <= 10; n++) begin
            cycle();
            if (sw_db[0] && first == 0) first = n;
            if (sw_rise[0]) begin
                rises++;
                rise_at = n;
            end
        end
        chk("db_latency", 32'(first), 32'(6));
        chk("rise_count", 32'(rises), 32'(1));
        chk("rise_cycle", 32'(rise_at), 32'(6));
        chk("db_others", 32'(sw_db[3:1]), 32'(0));

        // Glitch on channel 1 shorter than the debounce window.
        sw = 4'b0011;
        seen_db = 0; seen_rise = 0;
        for (int n = 0; n < 13; n++) begin
            if (n == 3) sw = 4'b0001;
            cycle();
            if (sw_db[1]) seen_db++;
            if (sw_rise[1]) seen_rise++;
        end
        chk("glitch_db", 32'(seen_db), 32'(0));
        chk("glitch_rise", 32'(seen_rise), 32'(0));

        // BLINK with all switches on; measure the tick spacing.
        sw = 4'b1111;
        repeat (8) cycle();
        t1 = -1; t2 = -1;
        for (int n = 1; n <= 30; n++) begin
            cycle();
            if (tick) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
        end
        chk("blink_period", 32'(t2 - t1), 32'(TP));

        // CHASE through a full wrap, then back to BLINK mid-period.
        mode = 2'd1;
        repeat (45) cycle();
        mode = 2'd0;
        cycle();
        tcnt = 0;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (n == 1) chk("blink_reload", 32'(led), 32'(4'b1010));
            if (tick && tcnt == 0) tcnt = n;
        end
        chk("tick_restart", 32'(tcnt), 32'(TP));

        // PWM dimming on the two low channels.
        mode = 2'd2;
        brightness = 4'd4;
        sw = 4'b0011;
        repeat (10) cycle();
        on_cnt = 0; hi_cnt = 0;
        for (int n = 0; n < 32; n++) begin
            cycle();
            if (led[0]) on_cnt++;
            if (led[3:2] != 2'b00) hi_cnt++;
        end
        chk("pwm_on_count", 32'(on_cnt), 32'(8));
        chk("pwm_upper_off", 32'(hi_cnt), 32'(0));
        brightness = 4'd0;
        cycle();
        on_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (led != '0) on_cnt++;
        end
        chk("pwm_zero", 32'(on_cnt), 32'(0));

        // Randomized switches, modes and brightness.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                sw[idx] = ~sw[idx];
            end
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) brightness = PB'($urandom_range(0, 15));
            cycle();
        end

        // Asynchronous reset in the middle of CHASE.
        mode = 2'd1;
        sw = 4'b1111;
        repeat (25) cycle();
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        mode = 2'd0;
        @(negedge clk_125);
        @(negedge clk_125);
        reset_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (n == 7)  chk("post_reset_init", 32'(led), 32'(4'b1010));
            if (n == 11) chk("post_reset_step", 32'(led), 32'(4'b0101));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
